// File: rtl/mm_wr_burst_sched_pkg.sv
// ----------------------------------------------------------------------------
// mm_wr_burst_sched_pkg
// Shared definitions for the memory-mapped write burst scheduler:
//   - state_e     : scheduler FSM state encoding
//   - clog2_min1  : ceil(log2(n)) with a floor of 1, used to size channel ids
// ----------------------------------------------------------------------------
package mm_wr_burst_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_WAIT,
    ST_UPD
  } state_e;

  // A single-channel build still needs a 1-bit channel id.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mm_wr_burst_sched_if.sv
// ----------------------------------------------------------------------------
// mm_wr_burst_sched_if
// Request handshake between the burst scheduler and the AXI write core.
//   write_req : scheduler -> core, request valid (held until req_resp)
//   req_len   : scheduler -> core, beats in the request
//   req_addr  : scheduler -> core, start byte address
//   req_ch    : scheduler -> core, granted channel (FIFO read mux select)
//   req_resp  : core -> scheduler, request accepted
//   req_done  : core -> scheduler, request finished (last beat + B response)
// Modports: master = scheduler side, slave = write-core side.
// ----------------------------------------------------------------------------
interface mm_wr_burst_sched_if #(
  parameter int ASIZE = 32,
  parameter int LSIZE = 9,
  parameter int CW    = 1
);
  logic             write_req;
  logic [LSIZE-1:0] req_len;
  logic [ASIZE-1:0] req_addr;
  logic [CW-1:0]    req_ch;
  logic             req_resp;
  logic             req_done;

  modport master (
    output write_req, req_len, req_addr, req_ch,
    input  req_resp, req_done
  );

  modport slave (
    input  write_req, req_len, req_addr, req_ch,
    output req_resp, req_done
  );
endinterface

// File: rtl/mm_ch_addr_gen.sv
// ----------------------------------------------------------------------------
// mm_ch_addr_gen
// Per-channel address state: line base, offset within the line, frame buffer
// index, pending line-end flag and a deferred frame-start flag.
//   count/tail/falign        : channel FIFO level, line-end and frame-start
//   base_addr/line_stride    : channel frame-0 base and line pitch
//   frame_stride             : distance between frame buffers
//   in_flight                : channel is granted or owns the active request
//   grant                    : channel is being granted this cycle (ARB)
//   upd/upd_tail/req_len     : UPD cycle for this channel, request kind, length
//   burst_ok/tail_ok         : eligibility for a full burst / a tail request
//   addr                     : next request address (line base + offset)
//   frame_idx                : current frame buffer
// ----------------------------------------------------------------------------
module mm_ch_addr_gen #(
  parameter int ASIZE          = 32,
  parameter int LSIZE          = 9,
  parameter int CSIZE          = 9,
  parameter int THRESHOLD      = 200,
  parameter int BYTES_PER_BEAT = 32,
  parameter int FB_NUM         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CSIZE-1:0] count,
  input  logic             tail,
  input  logic             falign,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [ASIZE-1:0] line_stride,
  input  logic [ASIZE-1:0] frame_stride,
  input  logic             in_flight,
  input  logic             grant,
  input  logic             upd,
  input  logic             upd_tail,
  input  logic [LSIZE-1:0] req_len,
  output logic             burst_ok,
  output logic             tail_ok,
  output logic [ASIZE-1:0] addr,
  output logic [1:0]       frame_idx
);

  logic [1:0]       frame_idx_q;
  logic [ASIZE-1:0] line_base_q;
  logic [ASIZE-1:0] offset_q;
  logic             tail_pend_q;
  logic             deferred_q;
  logic             loaded_q;

  logic [1:0]       fi_next;
  logic [ASIZE-1:0] eff_base;
  logic [ASIZE-1:0] frame_base;
  logic [ASIZE-1:0] burst_bytes;
  logic             zero_flush;
  logic             do_frame;
  logic             do_line;

  // Until the first grant, falign or line advance after reset the line base
  // follows base_addr, so software may program it any time before then.
  assign eff_base    = loaded_q ? line_base_q : base_addr;
  assign fi_next     = (frame_idx_q == 2'(FB_NUM - 1)) ? 2'd0 : frame_idx_q + 2'd1;
  assign frame_base  = base_addr + ASIZE'(fi_next) * frame_stride;
  assign burst_bytes = ASIZE'(req_len) * ASIZE'(BYTES_PER_BEAT);

  // A line end with an empty FIFO needs no request: advance the line at once.
  assign zero_flush = (tail || tail_pend_q) && (count == '0) && !in_flight && !falign;
  // Frame start on the active channel waits for its UPD cycle.
  assign do_frame   = (falign && !in_flight) || (upd && (deferred_q || falign));
  assign do_line    = (upd && upd_tail) || zero_flush;

  assign burst_ok  = int'(count) >= THRESHOLD;
  assign tail_ok   = tail_pend_q && (count != '0) && (int'(count) < THRESHOLD);
  assign addr      = eff_base + offset_q;
  assign frame_idx = frame_idx_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_idx_q <= '0;
      line_base_q <= '0;
      offset_q    <= '0;
      tail_pend_q <= 1'b0;
      deferred_q  <= 1'b0;
      loaded_q    <= 1'b0;
    end else if (do_frame) begin
      // Frame start wins over a same-cycle tail and clears any pending one.
      frame_idx_q <= fi_next;
      line_base_q <= frame_base;
      offset_q    <= '0;
      loaded_q    <= 1'b1;
      tail_pend_q <= 1'b0;
      deferred_q  <= 1'b0;
    end else begin
      if (falign) deferred_q <= 1'b1;
      if (do_line) begin
        line_base_q <= eff_base + line_stride;
        offset_q    <= '0;
        loaded_q    <= 1'b1;
        tail_pend_q <= 1'b0;
      end else if (upd) begin
        offset_q <= offset_q + burst_bytes;
      end else if (grant && !loaded_q) begin
        line_base_q <= base_addr;
        loaded_q    <= 1'b1;
      end
      // Placed last so a new line end during a tail UPD is not lost.
      if (tail && !falign && !zero_flush) tail_pend_q <= 1'b1;
    end
  end

endmodule

// File: rtl/mm_wr_burst_sched.sv
// ----------------------------------------------------------------------------
// mm_wr_burst_sched
// Round-robin write-burst scheduler for CH_NUM video-like stream channels.
// Each channel issues full bursts of THRESHOLD beats while its FIFO holds
// enough data, and a short tail request at line end. Addresses walk lines
// within a frame buffer; frame starts rotate across FB_NUM buffers.
//   axi_aclk/axi_resetn : clock, synchronous active-low reset
//   count/tail/falign   : per-channel FIFO level, line-end, frame-start
//   base_addr/line_stride/frame_stride : address layout
//   req_bus (master)    : request handshake to the AXI write core
//   frame_idx           : current frame buffer per channel (2 bits each)
//   busy                : scheduler outside IDLE
// ----------------------------------------------------------------------------
module mm_wr_burst_sched
  import mm_wr_burst_sched_pkg::*;
#(
  parameter int CH_NUM         = 2,
  parameter int ASIZE          = 32,
  parameter int LSIZE          = 9,
  parameter int CSIZE          = 9,
  parameter int THRESHOLD      = 200,
  parameter int BYTES_PER_BEAT = 32,
  parameter int FB_NUM         = 3
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic [CH_NUM*CSIZE-1:0] count,
  input  logic [CH_NUM-1:0]       tail,
  input  logic [CH_NUM-1:0]       falign,
  input  logic [CH_NUM*ASIZE-1:0] base_addr,
  input  logic [CH_NUM*ASIZE-1:0] line_stride,
  input  logic [ASIZE-1:0]        frame_stride,
  mm_wr_burst_sched_if.master     req_bus,
  output logic [CH_NUM*2-1:0]     frame_idx,
  output logic                    busy
);

  localparam int CW = clog2_min1(CH_NUM);

  state_e           state_q, state_d;
  logic [LSIZE-1:0] req_len_q;
  logic [ASIZE-1:0] req_addr_q;
  logic [CW-1:0]    req_ch_q;
  logic             req_tail_q;
  logic [CW-1:0]    rr_ptr_q;

  logic [CH_NUM-1:0] burst_ok, tail_ok, elig, grant, in_flight, upd;
  logic [ASIZE-1:0]  ch_addr  [CH_NUM];
  logic [CSIZE-1:0]  ch_count [CH_NUM];

  logic             grant_valid;
  logic [CW-1:0]    grant_ch;
  logic [ASIZE-1:0] grant_addr;
  logic [LSIZE-1:0] grant_len;
  logic             grant_tail;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign ch_count[i]  = count[i*CSIZE +: CSIZE];
    assign elig[i]      = burst_ok[i] || tail_ok[i];
    assign grant[i]     = (state_q == ST_ARB) && grant_valid && (grant_ch == CW'(i));
    assign upd[i]       = (state_q == ST_UPD) && (req_ch_q == CW'(i));
    assign in_flight[i] = grant[i] ||
                          ((state_q inside {ST_REQ, ST_WAIT, ST_UPD}) && (req_ch_q == CW'(i)));

    mm_ch_addr_gen #(
      .ASIZE(ASIZE), .LSIZE(LSIZE), .CSIZE(CSIZE), .THRESHOLD(THRESHOLD),
      .BYTES_PER_BEAT(BYTES_PER_BEAT), .FB_NUM(FB_NUM)
    ) u_ch (
      .clk         (axi_aclk),
      .rst_n       (axi_resetn),
      .count       (ch_count[i]),
      .tail        (tail[i]),
      .falign      (falign[i]),
      .base_addr   (base_addr[i*ASIZE +: ASIZE]),
      .line_stride (line_stride[i*ASIZE +: ASIZE]),
      .frame_stride(frame_stride),
      .in_flight   (in_flight[i]),
      .grant       (grant[i]),
      .upd         (upd[i]),
      .upd_tail    (req_tail_q),
      .req_len     (req_len_q),
      .burst_ok    (burst_ok[i]),
      .tail_ok     (tail_ok[i]),
      .addr        (ch_addr[i]),
      .frame_idx   (frame_idx[i*2 +: 2])
    );
  end

  // Round robin: scan distances k = CH_NUM..1 from the last grant so the
  // nearest eligible channel (smallest k) is the final assignment.
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    grant_addr  = '0;
    grant_len   = '0;
    grant_tail  = 1'b0;
    for (int k = CH_NUM; k >= 1; k--) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (elig[i] && (((int'(rr_ptr_q) + k) % CH_NUM) == i)) begin
          grant_valid = 1'b1;
          grant_ch    = CW'(i);
          grant_addr  = ch_addr[i];
          grant_tail  = !burst_ok[i];
          grant_len   = burst_ok[i] ? LSIZE'(THRESHOLD) : LSIZE'(ch_count[i]);
        end
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|elig) state_d = ST_ARB;
      // Eligibility can vanish between IDLE and ARB (live FIFO level).
      ST_ARB:  state_d = grant_valid ? ST_REQ : ST_IDLE;
      ST_REQ:  if (req_bus.req_resp) state_d = ST_WAIT;
      ST_WAIT: if (req_bus.req_done) state_d = ST_UPD;
      ST_UPD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      req_len_q  <= '0;
      req_addr_q <= '0;
      req_ch_q   <= '0;
      req_tail_q <= 1'b0;
      rr_ptr_q   <= CW'(CH_NUM - 1);
    end else if ((state_q == ST_ARB) && grant_valid) begin
      req_len_q  <= grant_len;
      req_addr_q <= grant_addr;
      req_ch_q   <= grant_ch;
      req_tail_q <= grant_tail;
      rr_ptr_q   <= grant_ch;
    end
  end

  assign req_bus.write_req = (state_q == ST_REQ);
  assign req_bus.req_len   = req_len_q;
  assign req_bus.req_addr  = req_addr_q;
  assign req_bus.req_ch    = req_ch_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mm_wr_burst_sched.sv
// ----------------------------------------------------------------------------
// tb_mm_wr_burst_sched
// Self-checking bench: the bench plays the AXI write core, pushes each
// expected request onto a scoreboard queue when it drives the stimulus that
// should cause it, and pops/compares when write_req appears.
// ----------------------------------------------------------------------------
module tb_mm_wr_burst_sched;

  localparam int CH_NUM = 2;
  localparam int ASIZE  = 32;
  localparam int LSIZE  = 9;
  localparam int CSIZE  = 9;

  localparam logic [31:0] BASE0  = 32'h1000_0000;
  localparam logic [31:0] BASE1  = 32'h2000_0000;
  localparam logic [31:0] LSTR0  = 32'h0000_2000;
  localparam logic [31:0] LSTR1  = 32'h0000_4000;
  localparam logic [31:0] FSTR   = 32'h0100_0000;
  localparam logic [31:0] BURST_BYTES = 32'd6400;  // 200 beats * 32 bytes

  typedef struct {
    int          ch;
    int          len;
    logic [31:0] addr;
  } exp_t;

  logic                    clk;
  logic                    axi_resetn;
  logic [CH_NUM*CSIZE-1:0] count;
  logic [CH_NUM-1:0]       tail;
  logic [CH_NUM-1:0]       falign;
  logic [CH_NUM*ASIZE-1:0] base_addr;
  logic [CH_NUM*ASIZE-1:0] line_stride;
  logic [ASIZE-1:0]        frame_stride;
  logic [CH_NUM*2-1:0]     frame_idx;
  logic                    busy;

  mm_wr_burst_sched_if #(.ASIZE(ASIZE), .LSIZE(LSIZE), .CW(1)) req_bus ();

  mm_wr_burst_sched #(
    .CH_NUM(CH_NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .CSIZE(CSIZE),
    .THRESHOLD(200), .BYTES_PER_BEAT(32), .FB_NUM(3)
  ) dut (
    .axi_aclk    (clk),
    .axi_resetn  (axi_resetn),
    .count       (count),
    .tail        (tail),
    .falign      (falign),
    .base_addr   (base_addr),
    .line_stride (line_stride),
    .frame_stride(frame_stride),
    .req_bus     (req_bus),
    .frame_idx   (frame_idx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_counts(input int c0, input int c1);
    count = {CSIZE'(c1), CSIZE'(c0)};
  endtask

  task automatic push_exp(input int ch, input int len, input logic [31:0] addr);
    exp_t e;
    e.ch = ch; e.len = len; e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    axi_resetn = 1'b0;
    tick(); tick();
    axi_resetn = 1'b1;
  endtask

  task automatic pulse_tail(input int ch);
    tail[ch] = 1'b1; tick(); tail = '0;
  endtask

  task automatic pulse_falign(input int ch);
    falign[ch] = 1'b1; tick(); falign = '0;
  endtask

  // Bounded wait for write_req, then compare against the scoreboard head.
  task automatic expect_req(input string tag);
    int waited;
    waited = 0;
    while (req_bus.write_req !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (req_bus.write_req !== 1'b1) begin
      check({tag, "_timeout"}, 64'(req_bus.write_req), 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    cur = exp_q.pop_front();
    check({tag, "_ch"},   64'(req_bus.req_ch),   64'(cur.ch));
    check({tag, "_len"},  64'(req_bus.req_len),  64'(cur.len));
    check({tag, "_addr"}, 64'(req_bus.req_addr), 64'(cur.addr));
  endtask

  task automatic accept(input string tag);
    req_bus.req_resp = 1'b1;
    tick();
    req_bus.req_resp = 1'b0;
    check({tag, "_wreq_drop"}, 64'(req_bus.write_req), 64'd0);
    check({tag, "_busy_wait"}, 64'(busy), 64'd1);
  endtask

  task automatic complete();
    req_bus.req_done = 1'b1;
    tick();
    req_bus.req_done = 1'b0;
    tick();
  endtask

  // A stray req_resp while idle must not start anything.
  task automatic expect_idle(input string tag);
    req_bus.req_resp = 1'b1;
    tick();
    req_bus.req_resp = 1'b0;
    tick(); tick(); tick();
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_wreq"}, 64'(req_bus.write_req), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_resetn       = 1'b0;
    count            = '0;
    tail             = '0;
    falign           = '0;
    base_addr        = {BASE1, BASE0};
    line_stride      = {LSTR1, LSTR0};
    frame_stride     = FSTR;
    req_bus.req_resp = 1'b0;
    req_bus.req_done = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_wreq",  64'(req_bus.write_req), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_len",   64'(req_bus.req_len), 64'd0);
    check("rst_addr",  64'(req_bus.req_addr), 64'd0);
    check("rst_ch",    64'(req_bus.req_ch), 64'd0);
    check("rst_fidx",  64'(frame_idx), 64'd0);

    // Single full burst, request held 10 cycles, stray req_done ignored
    set_counts(200, 0);
    push_exp(0, 200, BASE0);
    expect_req("burst1");
    for (int i = 0; i < 10; i++) begin
      req_bus.req_done = (i == 3);
      tick();
      check("hold_wreq", 64'(req_bus.write_req), 64'd1);
      check("hold_len",  64'(req_bus.req_len),   64'd200);
      check("hold_addr", 64'(req_bus.req_addr),  64'(BASE0));
    end
    req_bus.req_done = 1'b0;
    accept("burst1");
    push_exp(0, 200, BASE0 + BURST_BYTES);
    complete();
    expect_req("burst2");
    accept("burst2");
    set_counts(0, 0);
    complete();
    expect_idle("burst_end");

    // Round robin with both channels full
    do_reset();
    set_counts(250, 250);
    push_exp(0, 200, BASE0);
    push_exp(1, 200, BASE1);
    push_exp(0, 200, BASE0 + BURST_BYTES);
    expect_req("rr0"); accept("rr0"); complete();
    expect_req("rr1"); accept("rr1"); complete();
    expect_req("rr2"); accept("rr2");
    set_counts(0, 0);
    complete();
    expect_idle("rr_end");

    // Tail request, then line advance; empty-FIFO tail advances without request
    do_reset();
    set_counts(40, 0);
    tick(); tick(); tick();
    check("no_tail_yet_busy", 64'(busy), 64'd0);
    pulse_tail(0);
    push_exp(0, 40, BASE0);
    expect_req("tail"); accept("tail");
    set_counts(0, 0);
    complete();
    push_exp(0, 200, BASE0 + LSTR0);
    set_counts(200, 0);
    expect_req("after_tail"); accept("after_tail");
    set_counts(0, 0);
    complete();
    pulse_tail(0);
    tick();
    check("zero_tail_busy", 64'(busy), 64'd0);
    push_exp(0, 200, BASE0 + 2 * LSTR0);
    set_counts(200, 0);
    expect_req("after_ztail"); accept("after_ztail");
    set_counts(0, 0);
    complete();
    // falign and tail together: tail dropped, frame advances
    set_counts(40, 0);
    tail[0] = 1'b1; falign[0] = 1'b1;
    tick();
    tail = '0; falign = '0;
    expect_idle("fa_tail");
    check("fa_tail_fidx", 64'(frame_idx), 64'd1);
    set_counts(0, 0);

    // Deferred falign during WAIT, frame rotation
    do_reset();
    set_counts(200, 0);
    push_exp(0, 200, BASE0);
    expect_req("fr0"); accept("fr0");
    pulse_falign(0);
    check("defer_fidx", 64'(frame_idx), 64'd0);
    push_exp(0, 200, BASE0 + FSTR);
    complete();
    check("upd_fidx", 64'(frame_idx), 64'd1);
    expect_req("fr1"); accept("fr1");
    set_counts(0, 0);
    complete();
    pulse_falign(0);
    check("fidx_2", 64'(frame_idx), 64'd2);
    pulse_falign(0);
    check("fidx_wrap", 64'(frame_idx), 64'd0);
    push_exp(0, 200, BASE0);
    set_counts(200, 0);
    expect_req("fr_wrap"); accept("fr_wrap");
    set_counts(0, 0);
    complete();

    // Reset while waiting for req_done
    pulse_falign(0);
    push_exp(0, 200, BASE0 + FSTR);
    set_counts(200, 0);
    expect_req("mid"); accept("mid");
    axi_resetn = 1'b0;
    tick();
    check("mid_rst_wreq", 64'(req_bus.write_req), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_fidx", 64'(frame_idx), 64'd0);
    axi_resetn = 1'b1;
    push_exp(0, 200, BASE0);
    expect_req("post_rst"); accept("post_rst");
    set_counts(0, 0);
    complete();
    expect_idle("final");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
